// File: rtl/decomp_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decomp_fetch_ctrl                                            |
// | Description : Scanout fetch/pop sequencer for the 3-byte-to-4-pixel        |
// |               decompositor, with underrun flag and line/frame tracking.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decomp_fetch_ctrl #(
  parameter int ADDR_WIDTH   = 16,
  parameter int PIX_PER_LINE = 640,
  parameter int LINES        = 480
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  FrameStart,
  input  logic                  LineStart,
  input  logic                  PixTick,
  output logic                  MemRd,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemValid,
  input  logic                  DecFull,
  input  logic                  DecEmpty,
  output logic                  DecWr,
  output logic                  DecRd,
  output logic                  DecFlush,
  output logic                  LineDone,
  output logic                  Underrun,
  output logic                  Busy
);

  localparam int c_BYTES = PIX_PER_LINE * 3 / 4;
  localparam int c_BCW   = $clog2(c_BYTES + 1);
  localparam int c_PCW   = $clog2(PIX_PER_LINE + 1);
  localparam int c_LCW   = $clog2(LINES + 1);

  localparam logic [c_BCW-1:0]      c_BYTES_CNT = c_BCW'(c_BYTES);
  localparam logic [c_BCW-1:0]      c_BYTE_ONE  = c_BCW'(1);
  localparam logic [c_PCW-1:0]      c_PIX_CNT   = c_PCW'(PIX_PER_LINE);
  localparam logic [c_PCW-1:0]      c_PIX_ONE   = c_PCW'(1);
  localparam logic [c_LCW-1:0]      c_LAST_LINE = c_LCW'(LINES - 1);
  localparam logic [c_LCW-1:0]      c_LINE_ONE  = c_LCW'(1);
  localparam logic [ADDR_WIDTH-1:0] c_STRIDE    = ADDR_WIDTH'(c_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_ACTIVE    = 2'd2,
    S_LINE_END  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [ADDR_WIDTH-1:0]   r_memAddr;
  logic [ADDR_WIDTH-1:0]   r_lineBase;
  logic [c_BCW-1:0]        r_byteCnt;
  logic [c_PCW-1:0]        r_pixCnt;
  logic [c_LCW-1:0]        r_lineCnt;
  logic                    r_outstanding;
  logic                    r_underrun;

  logic w_active;
  logic w_abandon;
  logic w_kill;
  logic w_validHit;
  logic w_issue;
  logic w_pixSlot;
  logic w_lineComplete;
  logic w_lineBegin;

  // Reset, FrameStart and an abandoning LineStart all suppress every datapath action.
  assign w_active       = (r_state == S_ACTIVE);
  assign w_abandon      = w_active && LineStart && !FrameStart && !Reset;
  assign w_kill         = Reset || FrameStart || w_abandon;
  assign w_validHit     = MemValid && r_outstanding && !w_kill;
  assign w_issue        = w_active && !w_kill && (!r_outstanding || w_validHit) &&
                          !DecFull && (r_byteCnt < c_BYTES_CNT);
  assign w_pixSlot      = w_active && !w_kill && PixTick && (r_pixCnt < c_PIX_CNT);
  assign w_lineComplete = w_active && !w_kill && (r_byteCnt == c_BYTES_CNT) &&
                          (r_pixCnt == c_PIX_CNT);
  assign w_lineBegin    = (r_state == S_WAIT_LINE) && LineStart;

  assign MemAddr  = r_memAddr;
  assign Underrun = r_underrun;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    MemRd       = w_issue;
    DecWr       = w_validHit;
    DecRd       = w_pixSlot && !DecEmpty;
    DecFlush    = !Reset && (FrameStart || w_abandon);
    LineDone    = 1'b0;
    Busy        = 1'b0;
    case (r_state)
      S_IDLE:      w_stateNext = S_IDLE;
      S_WAIT_LINE: if (LineStart) w_stateNext = S_ACTIVE;
      S_ACTIVE: begin
        Busy = !Reset;
        if (w_lineComplete) w_stateNext = S_LINE_END;
      end
      S_LINE_END: begin
        LineDone    = !Reset;
        w_stateNext = (r_lineCnt == c_LAST_LINE) ? S_IDLE : S_WAIT_LINE;
      end
      default:     w_stateNext = S_IDLE;
    endcase
    if (FrameStart) w_stateNext = S_WAIT_LINE;
  end

  always_ff @(posedge Clk) begin
    if (Reset || FrameStart) begin
      r_memAddr     <= '0;
      r_lineBase    <= '0;
      r_byteCnt     <= '0;
      r_pixCnt      <= '0;
      r_lineCnt     <= '0;
      r_outstanding <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (w_abandon) begin
      // Skip the rest of the abandoned line; any read still in flight is orphaned.
      r_lineBase    <= r_lineBase + c_STRIDE;
      r_memAddr     <= r_lineBase + c_STRIDE;
      r_byteCnt     <= '0;
      r_pixCnt      <= '0;
      r_outstanding <= 1'b0;
      r_underrun    <= 1'b1;
    end else begin
      if (w_lineBegin) begin
        r_byteCnt <= '0;
        r_pixCnt  <= '0;
      end
      if (w_issue) begin
        r_memAddr     <= r_memAddr + c_ADDR_ONE;
        r_byteCnt     <= r_byteCnt + c_BYTE_ONE;
        r_outstanding <= 1'b1;
      end else if (w_validHit) begin
        r_outstanding <= 1'b0;
      end
      if (w_pixSlot) begin
        r_pixCnt <= r_pixCnt + c_PIX_ONE;
        if (DecEmpty) r_underrun <= 1'b1;
      end
      if (w_lineComplete) r_lineBase <= r_lineBase + c_STRIDE;
      if (r_state == S_LINE_END) r_lineCnt <= r_lineCnt + c_LINE_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decomp_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decomp_fetch_ctrl                                         |
// | Description : Self-checking bench for decomp_fetch_ctrl (8 px, 2 lines).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decomp_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, FrameStart, LineStart, PixTick, MemValid, DecFull, DecEmpty;
  logic        MemRd, DecWr, DecRd, DecFlush, LineDone, Underrun, Busy;
  logic [15:0] MemAddr;

  decomp_fetch_ctrl #(.ADDR_WIDTH(16), .PIX_PER_LINE(8), .LINES(2)) dut (
    .Clk(Clk), .Reset(Reset), .FrameStart(FrameStart), .LineStart(LineStart),
    .PixTick(PixTick), .MemRd(MemRd), .MemAddr(MemAddr), .MemValid(MemValid),
    .DecFull(DecFull), .DecEmpty(DecEmpty), .DecWr(DecWr), .DecRd(DecRd),
    .DecFlush(DecFlush), .LineDone(LineDone), .Underrun(Underrun), .Busy(Busy)
  );

  initial forever #5 Clk = ~Clk;

  // in  = {FrameStart, LineStart, PixTick, MemValid, DecFull, DecEmpty}
  // exp = {MemRd, DecWr, DecRd, DecFlush, LineDone, Busy, Underrun}
  typedef struct packed {
    logic [5:0]  in;
    logic [6:0]  exp;
    logic [15:0] addr;
  } vec_t;

  vec_t        vecs [12];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  memPipe = 2'b00;
  logic        fullReq = 1'b0;
  int          emptyMode = 0;
  bit          monPix = 1'b0;
  int          wrCnt = 0, rdCnt = 0, lineWr = 0, lineRd = 0;
  bit          lineDoneSeen = 1'b0;
  logic [15:0] expAddr [$];
  bit          pixExp [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(posedge Clk); #1;
    {FrameStart, LineStart, PixTick, MemValid, DecFull, DecEmpty} = v.in;
    @(negedge Clk);
    chk($sformatf("vec%0d_out", idx), {MemRd, DecWr, DecRd, DecFlush, LineDone, Busy, Underrun}, v.exp);
    chk($sformatf("vec%0d_addr", idx), MemAddr, v.addr);
  endtask

  // One cycle: 2-cycle-latency memory, byte/pixel occupancy model of the decompositor.
  task automatic tick(input logic fs, input logic ls, input logic pt);
    @(posedge Clk); #1;
    FrameStart = fs;
    LineStart  = ls;
    PixTick    = pt;
    MemValid   = memPipe[1];
    memPipe    = {memPipe[0], 1'b0};
    DecFull    = fullReq;
    DecEmpty   = (emptyMode == 1) ? 1'b1 :
                 (emptyMode == 2) ? 1'b0 : (((wrCnt * 4) / 3) <= rdCnt);
    if (pt && monPix) pixExp.push_back(!DecEmpty);
    @(negedge Clk);
    if (MemRd) begin
      chk("one_outstanding", memPipe[1], 0);
      memPipe[0] = 1'b1;
      if (expAddr.size() > 0) begin
        chk("rd_addr", MemAddr, expAddr.pop_front());
      end else begin
        checks++;
        errors++;
        $display("FAIL extra_rd: got read at %0d expected none", MemAddr);
      end
    end
    if (DecFull) chk("rd_while_full", MemRd, 0);
    if (pixExp.size() > 0) chk("dec_rd", DecRd, pixExp.pop_front());
    if (DecWr) begin wrCnt++; lineWr++; end
    if (DecRd) begin rdCnt++; lineRd++; end
    if (DecFlush) begin wrCnt = 0; rdCnt = 0; end
    if (LineDone) lineDoneSeen = 1'b1;
  endtask

  task automatic run_line(input logic [15:0] base, input int fullAt, input int fullLen,
                          input int firstTick);
    int   ticks;
    logic pt;
    for (int a = 0; a < 6; a++) expAddr.push_back(base + 16'(a));
    lineWr = 0; lineRd = 0; lineDoneSeen = 1'b0; ticks = 0;
    tick(1'b0, 1'b1, 1'b0);
    monPix = 1'b1;
    for (int c = 1; c <= 150 && !lineDoneSeen; c++) begin
      fullReq = (fullLen > 0) && (c >= fullAt) && (c < fullAt + fullLen);
      pt = (ticks < 8) && (c >= firstTick) && (((c - firstTick) % 4) == 0);
      if (pt) ticks++;
      tick(1'b0, 1'b0, pt);
      if (fullLen > 0 && c == fullAt + fullLen) chk("resume_after_full", MemRd, 1);
    end
    fullReq = 1'b0;
    monPix  = 1'b0;
    chk("line_done", lineDoneSeen, 1);
    chk("reads_left", expAddr.size(), 0);
    chk("line_wr", lineWr, 6);
    chk("line_rd", lineRd, 8);
    chk("line_no_underrun", Underrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; FrameStart = 1'b0; LineStart = 1'b0; PixTick = 1'b0;
    MemValid = 1'b0; DecFull = 1'b0; DecEmpty = 1'b1;

    vecs[0]  = '{6'b000001, 7'b0000000, 16'd0};  // idle
    vecs[1]  = '{6'b010001, 7'b0000000, 16'd0};  // LineStart in IDLE
    vecs[2]  = '{6'b001001, 7'b0000000, 16'd0};  // PixTick in IDLE
    vecs[3]  = '{6'b000000, 7'b0000000, 16'd0};  // still IDLE, no underrun
    vecs[4]  = '{6'b000100, 7'b0000000, 16'd0};  // stray MemValid
    vecs[5]  = '{6'b100001, 7'b0001000, 16'd0};  // FrameStart -> flush
    vecs[6]  = '{6'b001001, 7'b0000000, 16'd0};  // PixTick in WAIT_LINE
    vecs[7]  = '{6'b010000, 7'b0000000, 16'd0};  // LineStart
    vecs[8]  = '{6'b000001, 7'b1000010, 16'd0};  // first read at 0
    vecs[9]  = '{6'b000001, 7'b0000010, 16'd1};  // read outstanding
    vecs[10] = '{6'b101100, 7'b0001010, 16'd1};  // FrameStart + MemValid + PixTick
    vecs[11] = '{6'b000001, 7'b0000000, 16'd0};  // back in WAIT_LINE at 0

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_out", {MemRd, DecWr, DecRd, DecFlush, LineDone, Busy, Underrun}, 0);
    chk("reset_addr", MemAddr, 0);
    Reset = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Frame 1: two clean lines, then IDLE ignores LineStart
    tick(1'b1, 1'b0, 1'b0);
    chk("f1_flush", DecFlush, 1);
    run_line(16'd0, 0, 0, 10);
    run_line(16'd6, 0, 0, 10);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("idle_after_frame", Busy, 0);

    // Frame 2: back-pressure line, then an underrun cleared by FrameStart
    tick(1'b1, 1'b0, 1'b0);
    chk("f2_flush", DecFlush, 1);
    run_line(16'd0, 4, 10, 10);
    for (int a = 6; a < 12; a++) expAddr.push_back(16'(a));
    tick(1'b0, 1'b1, 1'b0);
    emptyMode = 1; monPix = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    emptyMode = 0; monPix = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    chk("underrun_set", Underrun, 1);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("underrun_sticky", Underrun, 1);
    tick(1'b1, 1'b0, 1'b0);
    chk("fs_flush", DecFlush, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("underrun_cleared", Underrun, 0);
    chk("flush_one_cycle", DecFlush, 0);
    expAddr.delete();

    // Frame 3: abandon a line after 3 bytes and 2 pixels
    for (int a = 0; a < 4; a++) expAddr.push_back(16'(a));
    lineWr = 0; lineRd = 0;
    tick(1'b0, 1'b1, 1'b0);
    monPix = 1'b1;
    for (int c = 1; c <= 7; c++) tick(1'b0, 1'b0, (c == 4) || (c == 6));
    monPix = 1'b0;
    chk("pre_abandon_wr", lineWr, 3);
    chk("pre_abandon_rd", lineRd, 2);
    chk("pre_abandon_underrun", Underrun, 0);
    expAddr.push_back(16'd6);
    tick(1'b0, 1'b1, 1'b0);
    chk("abandon_flush", DecFlush, 1);
    chk("abandon_no_rd", MemRd, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("late_valid_no_wr", DecWr, 0);
    chk("abandon_underrun", Underrun, 1);
    chk("abandon_next_rd", MemRd, 1);
    chk("abandon_reads_left", expAddr.size(), 0);
    chk("abandon_busy", Busy, 1);

    // FrameStart colliding with MemValid and PixTick
    tick(1'b0, 1'b0, 1'b0);
    emptyMode = 2;
    tick(1'b1, 1'b0, 1'b1);
    chk("fs_collide_wr", DecWr, 0);
    chk("fs_collide_rd", DecRd, 0);
    chk("fs_collide_flush", DecFlush, 1);
    emptyMode = 0;
    tick(1'b0, 1'b0, 1'b0);
    chk("fs_collide_addr", MemAddr, 0);
    chk("fs_collide_busy", Busy, 0);
    expAddr.push_back(16'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("fs_collide_wait_line", Busy, 1);
    chk("fs_collide_reads_left", expAddr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
